// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: write-data selects,
// forwarding-mux codes and controller FSM states.
package pipe_pkg;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;
  localparam logic [1:0] WD_EXT = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_ABORT = 2'd2
  } hz_state_e;

  // A stage can only forward if it writes a real register that matches.
  function automatic logic producer_hit(input logic we, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one EX-stage source register.
// MEM-stage producer wins over WB; x0 always reads the register file.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_rfwe,
  input  logic [4:0] wb_rd,
  input  logic       wb_rfwe,
  output logic [1:0] sel
);

  // Priority select: youngest producer first.
  always_comb begin
    sel = FWD_RF;
    if (rs == 5'd0) begin
      sel = FWD_RF;
    end else if (producer_hit(mem_rfwe, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (producer_hit(wb_rfwe, wb_rd, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with a bounded
// data-memory wait. Optional counters enabled by HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_re1,
  input  logic        ID_re2,
  input  logic [4:0]  EX_rs1,
  input  logic [4:0]  EX_rs2,
  input  logic [4:0]  EX_rd,
  input  logic        EX_rfwe,
  input  logic [1:0]  EX_wdsel,
  input  logic        EX_jump,
  input  logic [4:0]  MEM_rd,
  input  logic        MEM_rfwe,
  input  logic        MEM_dm_req,
  input  logic        dm_ack,
  input  logic [4:0]  WB_rd,
  input  logic        WB_rfwe,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_flush,
  output logic [1:0]  fwd_sel1,
  output logic [1:0]  fwd_sel2,
  output logic        dm_abort,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_abort_cnt,
`endif
  output logic        err_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  hz_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             err_timeout_r;
  logic             load_use_s;
  logic             freeze_s;
  logic             run_s;

  fwd_unit u_fwd1 (
    .rs       (EX_rs1),
    .mem_rd   (MEM_rd),
    .mem_rfwe (MEM_rfwe),
    .wb_rd    (WB_rd),
    .wb_rfwe  (WB_rfwe),
    .sel      (fwd_sel1)
  );

  fwd_unit u_fwd2 (
    .rs       (EX_rs2),
    .mem_rd   (MEM_rd),
    .mem_rfwe (MEM_rfwe),
    .wb_rd    (WB_rd),
    .wb_rfwe  (WB_rfwe),
    .sel      (fwd_sel2)
  );

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      cnt_r         <= '0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (state_r == ST_ABORT) begin
        err_timeout_r <= 1'b1;
      end else begin
        err_timeout_r <= err_timeout_r;
      end
    end
  end

  // Next state and wait-counter update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (MEM_dm_req && !dm_ack) begin
          state_s = ST_MWAIT;
          cnt_s   = CNT_W'(1);
        end else begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end
      end
      ST_MWAIT: begin
        if (dm_ack) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else if (cnt_r < CNT_LAST) begin
          state_s = ST_MWAIT;
          cnt_s   = cnt_r + CNT_W'(1);
        end else begin
          state_s = ST_ABORT;
          cnt_s   = '0;
        end
      end
      ST_ABORT: begin
        state_s = ST_RUN;
        cnt_s   = '0;
      end
      default: begin
        state_s = ST_RUN;
        cnt_s   = '0;
      end
    endcase
  end

  // Hazard detection terms.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    load_use_s = EX_rfwe && (EX_wdsel == WD_DM) && (EX_rd != 5'd0) &&
                 ((ID_re1 && (ID_rs1 == EX_rd)) || (ID_re2 && (ID_rs2 == EX_rd)));
    if (run_s) begin
      freeze_s = MEM_dm_req && !dm_ack;
    end else if (state_r == ST_MWAIT) begin
      freeze_s = !dm_ack && (cnt_r < CNT_LAST);
    end else begin
      freeze_s = 1'b0;
    end
  end

  // Stall/flush outputs: freeze beats jump, jump beats load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    dm_abort     = 1'b0;
    if (freeze_s) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_r == ST_ABORT) begin
      dm_abort     = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (run_s && EX_jump) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (run_s && load_use_s) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_stall = 1'b0;
    end
  end

  assign err_timeout = err_timeout_r;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_r, perf_flush_r, perf_abort_r;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
      perf_abort_r <= 32'd0;
    end else begin
      perf_stall_r <= perf_stall_r + {31'd0, pc_stall};
      perf_flush_r <= perf_flush_r + {31'd0, id_ex_flush};
      perf_abort_r <= perf_abort_r + {31'd0, dm_abort};
    end
  end

  assign perf_stall_cyc = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
  assign perf_abort_cnt = perf_abort_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (WAIT_MAX=4): the driver queues the
// expected output vector per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
  logic ID_re1, ID_re2, EX_rfwe, EX_jump, MEM_rfwe, MEM_dm_req, dm_ack, WB_rfwe;
  logic [1:0] EX_wdsel;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, dm_abort, err_timeout;
  logic [1:0] fwd_sel1, fwd_sel2;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_abort_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_re1(ID_re1), .ID_re2(ID_re2),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_rfwe(EX_rfwe),
    .EX_wdsel(EX_wdsel), .EX_jump(EX_jump),
    .MEM_rd(MEM_rd), .MEM_rfwe(MEM_rfwe), .MEM_dm_req(MEM_dm_req), .dm_ack(dm_ack),
    .WB_rd(WB_rd), .WB_rfwe(WB_rfwe),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .dm_abort(dm_abort),
`ifdef HAZARD_PERF_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
    .perf_abort_cnt(perf_abort_cnt),
`endif
    .err_timeout(err_timeout)
  );

  // Vector: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush
  //         ex_mem_stall mem_wb_flush fwd1[2] fwd2[2] dm_abort err_timeout
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] LU   = 13'h1900;
  localparam logic [12:0] JMP  = 13'h0500;
  localparam logic [12:0] FRZ  = 13'h1AC0;
  localparam logic [12:0] ABT  = 13'h0042;
  localparam logic [12:0] ERR  = 13'h0001;
  localparam logic [12:0] F1M  = 13'h0010;
  localparam logic [12:0] F2M  = 13'h0004;
  localparam logic [12:0] F2W  = 13'h0008;

  logic [12:0] act;
  assign act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_flush, fwd_sel1, fwd_sel2, dm_abort, err_timeout};

  logic [12:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
    end
  end

  task automatic clr();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_re1 = 1'b0; ID_re2 = 1'b0;
    EX_rs1 = 5'd0; EX_rs2 = 5'd0; EX_rd = 5'd0; EX_rfwe = 1'b0;
    EX_wdsel = WD_ALU; EX_jump = 1'b0;
    MEM_rd = 5'd0; MEM_rfwe = 1'b0; MEM_dm_req = 1'b0; dm_ack = 1'b0;
    WB_rd = 5'd0; WB_rfwe = 1'b0;
  endtask

  task automatic set_lu();
    EX_rd = 5'd7; EX_rfwe = 1'b1; EX_wdsel = WD_DM; ID_re2 = 1'b1; ID_rs2 = 5'd7;
  endtask

  task automatic expect_cyc(input logic [12:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk); #1;
    expect_cyc(NONE, "reset");
    rst_n = 1'b1;

    // Forwarding
    EX_rd = 5'd5; EX_rfwe = 1'b1; ID_re1 = 1'b1; ID_rs1 = 5'd5;
    expect_cyc(NONE, "alu_no_stall");
    clr(); EX_rs1 = 5'd5; MEM_rd = 5'd5; MEM_rfwe = 1'b1;
    expect_cyc(F1M, "fwd_mem");
    WB_rd = 5'd5; WB_rfwe = 1'b1;
    expect_cyc(F1M, "fwd_mem_over_wb");
    clr(); MEM_rd = 5'd0; MEM_rfwe = 1'b1;
    expect_cyc(NONE, "fwd_x0");
    clr(); EX_rs2 = 5'd9; MEM_rd = 5'd9; WB_rd = 5'd9; WB_rfwe = 1'b1;
    expect_cyc(F2W, "fwd_wb_mem_nowe");

    // Load-use
    clr(); set_lu();
    expect_cyc(LU, "load_use");
    clr(); EX_rs2 = 5'd7; MEM_rd = 5'd7; MEM_rfwe = 1'b1; ID_re2 = 1'b1; ID_rs2 = 5'd7;
    expect_cyc(F2M, "after_bubble");
    clr(); set_lu(); ID_re2 = 1'b0;
    expect_cyc(NONE, "lu_no_read");
    clr(); set_lu(); EX_rd = 5'd0; ID_rs2 = 5'd0;
    expect_cyc(NONE, "lu_rd0");

    // Jump overrides load-use
    clr(); set_lu(); EX_jump = 1'b1;
    expect_cyc(JMP, "jump_vs_lu");

    // Wait with ack on the fourth cycle, jump held off while frozen
    clr(); MEM_dm_req = 1'b1; EX_jump = 1'b1;
    expect_cyc(FRZ, "wait0_jump");
    expect_cyc(FRZ, "wait1");
    EX_jump = 1'b0;
    expect_cyc(FRZ, "wait2");
    dm_ack = 1'b1;
    expect_cyc(NONE, "wait_ack");
    clr(); set_lu();
    expect_cyc(LU, "run_after_ack");

    // Same-cycle ack: no wait
    clr(); MEM_dm_req = 1'b1; dm_ack = 1'b1;
    expect_cyc(NONE, "ack_same");
    clr(); set_lu();
    expect_cyc(LU, "run_after_same");

    // Timeout
    clr(); MEM_dm_req = 1'b1;
    expect_cyc(FRZ, "to0");
    expect_cyc(FRZ, "to1");
    expect_cyc(FRZ, "to2");
    expect_cyc(NONE, "to_last");
    expect_cyc(ABT, "abort");
    clr();
    expect_cyc(ERR, "err_set");
    set_lu();
    expect_cyc(LU | ERR, "run_after_abort");
    clr();
    expect_cyc(ERR, "err_sticky");

    // Async reset in the middle of a wait
    MEM_dm_req = 1'b1;
    expect_cyc(FRZ | ERR, "rw0");
    expect_cyc(FRZ | ERR, "rw1");
    clr(); set_lu(); dm_ack = 1'b1; rst_n = 1'b0;
    expect_cyc(LU, "reset_mid_wait");
    rst_n = 1'b1;
    expect_cyc(LU, "run_after_reset");
    clr();
    expect_cyc(NONE, "idle_end");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
